// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types, constants and access-fault check for mem_responder
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Misaligned, below the window, or past the last word of the window.
  function automatic logic access_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned addr_w);
    logic [31:0] off;
    if (addr[1:0] != 2'b00) return 1'b1;
    if (addr < base) return 1'b1;
    off = addr - base;
    return (64'(off >> 2) >= (64'd1 << addr_w));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU data-bus request/response bundle for mem_responder
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, be, input ready, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata, err, busy);
endinterface

// File: rtl/resp_ram.sv
// rtl/resp_ram.sv - single-port word array with per-byte write enables and registered read
module resp_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        wbe,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wbe[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        q <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state data memory responder; MEM_RESP_BYTE_EN enables byte-masked stores
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES must be within 0..15");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("mem_responder: BASE_ADDR must be word aligned");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               we_q, fault_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic               in_idle, cur_we, cur_fault;
  logic [31:0]        cur_addr, cur_wdata;
  logic               ram_en;
  logic [3:0]         ram_wbe;
  logic [ADDR_W-1:0]  ram_idx;
  logic [31:0]        ram_q, resp_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the RAM access shares the acceptance edge, so it
  // must see the live request rather than the not-yet-latched copy.
  assign in_idle   = (state_q == IDLE);
  assign cur_we    = in_idle ? bus.we    : we_q;
  assign cur_addr  = in_idle ? bus.addr  : addr_q;
  assign cur_wdata = in_idle ? bus.wdata : wdata_q;
  assign cur_fault = in_idle ? access_fault(bus.addr, BASE_ADDR, ADDR_W) : fault_q;

  assign ram_idx = ADDR_W'((cur_addr - BASE_ADDR) >> 2);
  assign ram_en  = (state_d == RESP) && !reset && !cur_fault;

`ifdef MEM_RESP_BYTE_EN
  logic [3:0] be_q;
  always_ff @(posedge clk) begin
    if (accept) be_q <= bus.be;
  end
  assign ram_wbe = in_idle ? bus.be : be_q;
`else
  logic unused_be;
  assign unused_be = ^bus.be;
  assign ram_wbe   = 4'hF;
`endif

  resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_we),
    .wbe   (ram_wbe),
    .idx   (ram_idx),
    .wdata (cur_wdata),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP) rdata_q <= resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.we;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
      fault_q <= access_fault(bus.addr, BASE_ADDR, ADDR_W);
    end
  end

  assign resp_data = (we_q || fault_q) ? 32'h0 : ram_q;

  assign bus.ready = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && fault_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = (state_q == RESP) ? resp_data : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder (WAIT_CYCLES 2 and 0)
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus2.slave));
  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  int checks = 0;
  int fails  = 0;

  logic [31:0] model   [1024];
  bit          written [1024];

  function automatic bit exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 1024);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [9:0] w;
    if (exp_fault(a)) return;
    w = a[11:2];
`ifdef MEM_RESP_BYTE_EN
    for (int i = 0; i < 4; i++) if (b[i]) model[w][8*i +: 8] = d[8*i +: 8];
    if (b == 4'hF) written[w] = 1'b1;
`else
    model[w] = d;
    if (b == b) written[w] = 1'b1;
`endif
  endtask

  // Drives one transaction on the 2-wait-state instance and reports what came back.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     output logic [31:0] rd, output bit e, output int lat, output int nbusy);
    bit done;
    rd = '0; e = 1'b0; lat = 0; nbusy = 0; done = 1'b0;
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.be = b;
    @(posedge clk);
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (bus2.busy) nbusy++;
      if (bus2.ready) begin
        lat = i; rd = bus2.rdata; e = bus2.err; done = 1'b1;
      end else begin
        bus2.addr  = a ^ 32'h4;
        bus2.wdata = ~d;
      end
    end
    bus2.req = 1'b0; bus2.addr = a; bus2.wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus2.ready, bus2.err, bus2.busy, bus2.rdata} !== 35'h0) begin
      fails++; $display("FAIL reset_w2: got %h expected 0", {bus2.ready, bus2.err, bus2.busy, bus2.rdata});
    end
    checks++;
    if ({bus0.ready, bus0.err, bus0.busy, bus0.rdata} !== 35'h0) begin
      fails++; $display("FAIL reset_w0: got %h expected 0", {bus0.ready, bus0.err, bus0.busy, bus0.rdata});
    end
    reset = 1'b0;
  endtask

  task automatic test_first_load();
    logic [31:0] rd; bit e; int lat, nb;
    txn(1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (lat !== 3) begin fails++; $display("FAIL first_load_latency: got %0d expected 3", lat); end
    checks++; if (nb !== 3) begin fails++; $display("FAIL first_load_busy: got %0d expected 3", nb); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL first_load_err: got %0b expected 0", e); end
    @(negedge clk);
    checks++;
    if ({bus2.busy, bus2.ready} !== 2'b00) begin
      fails++; $display("FAIL first_load_idle: got %b expected 00", {bus2.busy, bus2.ready});
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; bit e; int lat, nb;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, nb);
    model_store(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (lat !== 3) begin fails++; $display("FAIL store_latency: got %0d expected 3", lat); end
    checks++; if ({e, rd} !== 33'h0) begin fails++; $display("FAIL store_resp: got %h expected 0", {e, rd}); end
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (lat !== 3) begin fails++; $display("FAIL load_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data: got %h expected deadbeef", rd); end
    @(negedge clk);
    checks++;
    if (bus2.rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rdata_hold: got %h expected deadbeef", bus2.rdata);
    end
  endtask

  task automatic test_byte_en();
    logic [31:0] rd, exp1, exp2; bit e; int lat, nb;
`ifdef MEM_RESP_BYTE_EN
    exp1 = 32'h11BB33DD; exp2 = 32'h11BB33DD;
`else
    exp1 = 32'hAABBCCDD; exp2 = 32'hFFFFFFFF;
`endif
    txn(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, e, lat, nb);
    model_store(32'h20, 32'h11223344, 4'b1111);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat, nb);
    model_store(32'h20, 32'hAABBCCDD, 4'b0101);
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (rd !== exp1) begin fails++; $display("FAIL byte_en_merge: got %h expected %h", rd, exp1); end
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat, nb);
    model_store(32'h20, 32'hFFFFFFFF, 4'b0000);
    checks++;
    if ({lat, e} !== {32'd3, 1'b0}) begin
      fails++; $display("FAIL byte_en_zero_resp: got lat %0d err %0b expected lat 3 err 0", lat, e);
    end
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (rd !== exp2) begin fails++; $display("FAIL byte_en_zero_data: got %h expected %h", rd, exp2); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; bit e; int lat, nb;
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, e, lat, nb);
    model_store(32'h0, 32'hCAFEF00D, 4'hF);
    txn(1'b1, 32'hFFC, 32'h600DF00D, 4'hF, rd, e, lat, nb);
    model_store(32'hFFC, 32'h600DF00D, 4'hF);
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL last_word_err: got %0b expected 0", e); end
    txn(1'b0, 32'h2, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if ({e, rd} !== {1'b1, 32'h0}) begin fails++; $display("FAIL misaligned_load: got %h expected 100000000", {e, rd}); end
    txn(1'b1, 32'h1000, 32'h0BAD0BAD, 4'hF, rd, e, lat, nb);
    checks++; if ({e, rd} !== {1'b1, 32'h0}) begin fails++; $display("FAIL range_store: got %h expected 100000000", {e, rd}); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL range_store_latency: got %0d expected 3", lat); end
    txn(1'b1, 32'h11, 32'h0BAD0BAD, 4'hF, rd, e, lat, nb);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL misaligned_store: got %0b expected 1", e); end
    txn(1'b0, 32'h0, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL fault_no_write_w0: got %h expected cafef00d", rd); end
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL fault_no_write_w4: got %h expected deadbeef", rd); end
    txn(1'b0, 32'hFFC, 32'h0, 4'hF, rd, e, lat, nb);
    checks++; if (rd !== 32'h600DF00D) begin fails++; $display("FAIL last_word_data: got %h expected 600df00d", rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp_rd; logic [3:0] b; logic [9:0] widx;
    bit w, e, exp_e; int k, lat, nb;
    for (int n = 0; n < 40; n++) begin
      k    = int'($urandom_range(0, 9));
      widx = 10'($urandom_range(64, 79));
      a    = {20'h0, widx, 2'b00};
      if (k == 0) a = a + 32'($urandom_range(1, 3));
      else if (k == 1) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      w = 1'($urandom_range(0, 1));
      if (!w && !exp_fault(a) && !written[a[11:2]]) w = 1'b1;
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      exp_e  = exp_fault(a);
      exp_rd = (w || exp_e) ? 32'h0 : model[a[11:2]];
      txn(w, a, d, b, rd, e, lat, nb);
      if (w) model_store(a, d, b);
      checks++;
      if ({lat, nb, e, rd} !== {32'd3, 32'd3, exp_e, exp_rd}) begin
        fails++;
        $display("FAIL random_%0d: we %0b addr %h got lat %0d busy %0d err %0b rdata %h expected lat 3 busy 3 err %0b rdata %h",
                 n, w, a, lat, nb, e, rd, exp_e, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dv [6];
    logic exp_r;
    int k;
    for (int i = 0; i < 6; i++) dv[i] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      k = 0;
      @(negedge clk);
      bus0.req = 1'b1; bus0.we = (pass == 0); bus0.addr = 32'h200; bus0.wdata = dv[0]; bus0.be = 4'hF;
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        exp_r = (n % 2 == 1);
        checks++;
        if (bus0.ready !== exp_r) begin
          fails++; $display("FAIL b2b_ready_p%0d_c%0d: got %b expected %b", pass, n, bus0.ready, exp_r);
        end
        if (bus0.ready) begin
          if (pass == 1) begin
            checks++;
            if ({bus0.err, bus0.rdata} !== {1'b0, dv[k]}) begin
              fails++; $display("FAIL b2b_load_%0d: got %h expected %h", k, {bus0.err, bus0.rdata}, {1'b0, dv[k]});
            end
          end
          k++;
          if (k < 6) begin
            bus0.addr = 32'h200 + 32'(4 * k); bus0.wdata = dv[k];
          end
        end
        if (n == 12) bus0.req = 1'b0;
      end
      checks++;
      if (k !== 6) begin fails++; $display("FAIL b2b_count_p%0d: got %0d expected 6", pass, k); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit e, seen; int lat, nb;
    txn(1'b1, 32'h8, 32'h12345678, 4'hF, rd, e, lat, nb);
    model_store(32'h8, 32'h12345678, 4'hF);
    for (int dly = 1; dly <= 2; dly++) begin
      seen = 1'b0;
      @(negedge clk);
      bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h8; bus2.wdata = 32'h5; bus2.be = 4'hF;
      @(posedge clk);
      repeat (dly) begin @(negedge clk); if (bus2.ready) seen = 1'b1; end
      reset = 1'b1;
      repeat (2) begin @(negedge clk); if (bus2.ready) seen = 1'b1; end
      reset = 1'b0; bus2.req = 1'b0;
      repeat (3) begin @(negedge clk); if (bus2.ready) seen = 1'b1; end
      checks++;
      if ({seen, bus2.busy} !== 2'b00) begin
        fails++; $display("FAIL reset_abort_%0d: got ready_seen/busy %b expected 00", dly, {seen, bus2.busy});
      end
      txn(1'b0, 32'h8, 32'h0, 4'hF, rd, e, lat, nb);
      checks++;
      if (rd !== 32'h12345678) begin
        fails++; $display("FAIL reset_no_write_%0d: got %h expected 12345678", dly, rd);
      end
    end
  endtask

  initial begin
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.be = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0;
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;
    test_reset();
    test_first_load();
    test_store_load();
    test_byte_en();
    test_faults();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
